// File: rtl/instr_mem_loader_if.sv
// Fetch and boot-load signals of the instruction memory.
// The master is the CPU/loader side; the slave is instr_mem_loader.
interface instr_mem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Q;
  logic              MISALIGN;
  logic              LD_START;
  logic              LD_VALID;
  logic [7:0]        LD_BYTE;
  logic              LD_LAST;
  logic              LD_READY;
  logic              LOADING;
  logic              LD_DONE;
  logic              LD_ERR;
  logic [CNT_W-1:0]  LD_COUNT;

  modport master (
    output ADDR, LD_START, LD_VALID, LD_BYTE, LD_LAST,
    input  Q, MISALIGN, LD_READY, LOADING, LD_DONE, LD_ERR, LD_COUNT
  );

  modport slave (
    input  ADDR, LD_START, LD_VALID, LD_BYTE, LD_LAST,
    output Q, MISALIGN, LD_READY, LOADING, LD_DONE, LD_ERR, LD_COUNT
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream boot loader; zero-filled after RESET.
// Fetch is combinational (REG_OUT=0) or 1-cycle registered; loader is ready only in LOAD.
module instr_mem_loader #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 128,
  parameter int                 REG_OUT  = 0,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  instr_mem_loader_if.slave   bus
);
  localparam int BPW   = DATA_W / 8;
  localparam int BSH   = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int BCW   = (BSH > 0) ? BSH : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IW    = ADDR_W + PTR_W;

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_clr_ptr;
  logic [BCW-1:0]     r_byte_cnt;
  logic [DATA_W-1:0]  r_asm;
  logic [CNT_W-1:0]   r_ld_count;
  logic               r_ld_err;
  logic               r_ld_done;

  logic               w_accept;
  logic               w_word_done;
  logic               w_full;
  logic [BCW-1:0]     w_byte_pos;
  logic [DATA_W-1:0]  w_word;
  logic               w_we;
  logic [PTR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]  w_wdata;
  logic [IW-1:0]      w_idx;
  logic [DATA_W-1:0]  w_q;
  logic               w_mis;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_ptr == PTR_W'(DEPTH - 1)) w_state_nxt = S_RUN;
      S_RUN:   if (bus.LD_START)                   w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept && bus.LD_LAST)        w_state_nxt = S_RUN;
      default:                                     w_state_nxt = S_CLEAR;
    endcase
  end

  // Each byte is OR-ed into its final lane, so a short last word keeps zero low bytes.
  always_comb begin
    w_accept    = (r_state == S_LOAD) && bus.LD_VALID;
    w_byte_pos  = BCW'(BPW - 1) - r_byte_cnt;
    w_word      = r_asm | (DATA_W'(bus.LD_BYTE) << {w_byte_pos, 3'b000});
    w_word_done = w_accept && ((r_byte_cnt == BCW'(BPW - 1)) || bus.LD_LAST);
    w_full      = (r_ld_count == CNT_W'(DEPTH));
    w_we        = 1'b0;
    w_waddr     = r_clr_ptr;
    w_wdata     = '0;
    if (r_state == S_CLEAR) begin
      w_we = !RESET;
    end else if (w_word_done && !w_full) begin
      w_we    = !RESET;
      w_waddr = r_ld_count[PTR_W-1:0];
      w_wdata = w_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clr_ptr  <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_ld_count <= '0;
      r_ld_err   <= 1'b0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_done <= w_accept && bus.LD_LAST;
      if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
      if (r_state == S_RUN && bus.LD_START) begin
        r_byte_cnt <= '0;
        r_asm      <= '0;
        r_ld_count <= '0;
        r_ld_err   <= 1'b0;
      end else if (w_accept) begin
        if (w_word_done) begin
          r_byte_cnt <= '0;
          r_asm      <= '0;
          if (w_full) r_ld_err   <= 1'b1;
          else        r_ld_count <= r_ld_count + 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_asm      <= w_word;
        end
      end
    end
  end

  // Fetch is served only in RUN; the sub-word address bits only flag misalignment.
  assign w_idx = IW'(bus.ADDR) >> BSH;
  assign w_q   = (r_state == S_RUN && w_idx < IW'(DEPTH)) ? r_mem[w_idx[PTR_W-1:0]] : NOP_WORD;

  if (BSH > 0) begin : g_mis
    assign w_mis = (r_state == S_RUN) && (|bus.ADDR[BSH-1:0]);
  end else begin : g_nomis
    assign w_mis = 1'b0;
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_W-1:0] r_q;
    logic              r_mis;
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_q   <= NOP_WORD;
        r_mis <= 1'b0;
      end else begin
        r_q   <= w_q;
        r_mis <= w_mis;
      end
    end
    assign bus.Q        = r_q;
    assign bus.MISALIGN = r_mis;
  end else begin : g_comb_out
    assign bus.Q        = w_q;
    assign bus.MISALIGN = w_mis;
  end

  assign bus.LD_READY = (r_state == S_LOAD);
  assign bus.LOADING  = (r_state != S_RUN);
  assign bus.LD_DONE  = r_ld_done;
  assign bus.LD_ERR   = r_ld_err;
  assign bus.LD_COUNT = r_ld_count;
endmodule
